// File: rtl/mem_pipe.sv
// Memory stage of an in-order pipeline. ALU results pass straight through.
// Loads either complete in the issue cycle or wait for the response, with a
// timeout. An orphaned response, left behind by a flush or a timeout, is
// dropped in DRAIN. Sub-word load data is extracted and sign/zero extended.
module mem_pipe #(
  parameter int XLEN         = 32,
  parameter int RF_AW        = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex2mem_valid,
  input  logic             ex2mem_reg_wen,
  input  logic [RF_AW-1:0] ex2mem_reg_waddr,
  input  logic [XLEN-1:0]  ex2mem_alu_out,
  input  logic             ex2mem_mem_rd,
  input  logic [2:0]       ex2mem_ld_type,
  input  logic             ex2mem_ill_instr,
  input  logic             mem_flush,
  input  logic             lsu_rvalid,
  input  logic [XLEN-1:0]  lsu_rdata,
  output logic             mem_stall,
  output logic             mem2wb_valid,
  output logic             mem2wb_reg_wen,
  output logic             mem2wb_ill_instr,
  output logic             mem2wb_ld_fault,
  output logic [RF_AW-1:0] mem2wb_reg_waddr,
  output logic [XLEN-1:0]  mem2wb_reg_wdata,
  output logic             mem_fwd_wen,
  output logic [RF_AW-1:0] mem_fwd_addr,
  output logic [XLEN-1:0]  mem_fwd_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Last WAIT count before the load is declared faulted.
  localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            stall;
  logic            retire;
  logic            ret_fault;
  logic            ret_load;
  logic [XLEN-1:0] load_data;

  // Select the addressed byte/half of the word and extend it; reserved
  // funct3 codes behave as LW.
  function automatic logic [XLEN-1:0] extend_load(input logic [2:0]      ld_type,
                                                  input logic [1:0]      addr_lo,
                                                  input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*addr_lo +: 8];
    h = rdata[16*addr_lo[1] +: 16];
    case (ld_type)
      3'b000:  extend_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  extend_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  extend_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  extend_load = {{(XLEN-16){1'b0}}, h};
      default: extend_load = rdata;
    endcase
  endfunction

  assign load_data = extend_load(ex2mem_ld_type, ex2mem_alu_out[1:0], lsu_rdata);

  // Forwarding of the in-flight ALU result (loads are not forwardable here).
  assign mem_fwd_wen  = ex2mem_valid & ex2mem_reg_wen & ~ex2mem_mem_rd & ~mem_flush;
  assign mem_fwd_addr = ex2mem_reg_waddr;
  assign mem_fwd_data = ex2mem_alu_out;

  // The stall is forced low while reset is asserted so EX/MEM never freezes.
  assign mem_stall = stall & ~rst;

  // Next-state, timeout counter, stall and retire decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    retire    = 1'b0;
    ret_fault = 1'b0;
    ret_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex2mem_valid) begin
          if (mem_flush) begin
            // A killed load without its response still has one in flight.
            if (ex2mem_mem_rd && !lsu_rvalid) state_d = S_DRAIN;
          end else if (!ex2mem_mem_rd) begin
            retire = 1'b1;
          end else if (lsu_rvalid) begin
            retire   = 1'b1;
            ret_load = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        // Flush wins over both completion and timeout.
        if (mem_flush) begin
          state_d = lsu_rvalid ? S_IDLE : S_DRAIN;
        end else if (lsu_rvalid) begin
          retire   = 1'b1;
          ret_load = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          retire    = 1'b1;
          ret_fault = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (lsu_rvalid) state_d = S_IDLE;
        // Loads wait for IDLE; other instructions flow through normally.
        if (ex2mem_valid && ex2mem_mem_rd) begin
          stall = 1'b1;
        end else if (ex2mem_valid && !mem_flush) begin
          retire = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and MEM/WB pipeline register; waddr/wdata hold when idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      mem2wb_valid     <= 1'b0;
      mem2wb_reg_wen   <= 1'b0;
      mem2wb_ill_instr <= 1'b0;
      mem2wb_ld_fault  <= 1'b0;
      mem2wb_reg_waddr <= '0;
      mem2wb_reg_wdata <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      mem2wb_valid     <= retire;
      mem2wb_reg_wen   <= retire & ~ret_fault & ex2mem_reg_wen;
      mem2wb_ill_instr <= retire & ex2mem_ill_instr;
      mem2wb_ld_fault  <= ret_fault;
      if (retire) begin
        mem2wb_reg_waddr <= ex2mem_reg_waddr;
        // A faulted load has no data; the previous write data is kept.
        if (!ret_fault) mem2wb_reg_wdata <= ret_load ? load_data : ex2mem_alu_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: the driver pushes expected retirements into a
// queue, a negedge monitor pops and compares each retirement the DUT makes.
module tb_mem_pipe;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  typedef struct {
    logic             wen;
    logic [RF_AW-1:0] waddr;
    logic [XLEN-1:0]  wdata;
    logic             ill;
    logic             fault;
  } ret_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex2mem_valid;
  logic             ex2mem_reg_wen;
  logic [RF_AW-1:0] ex2mem_reg_waddr;
  logic [XLEN-1:0]  ex2mem_alu_out;
  logic             ex2mem_mem_rd;
  logic [2:0]       ex2mem_ld_type;
  logic             ex2mem_ill_instr;
  logic             mem_flush;
  logic             lsu_rvalid;
  logic [XLEN-1:0]  lsu_rdata;
  logic             mem_stall;
  logic             mem2wb_valid;
  logic             mem2wb_reg_wen;
  logic             mem2wb_ill_instr;
  logic             mem2wb_ld_fault;
  logic [RF_AW-1:0] mem2wb_reg_waddr;
  logic [XLEN-1:0]  mem2wb_reg_wdata;
  logic             mem_fwd_wen;
  logic [RF_AW-1:0] mem_fwd_addr;
  logic [XLEN-1:0]  mem_fwd_data;

  int   total = 0;
  int   bad   = 0;
  ret_t exp_q[$];

  mem_pipe #(.XLEN(XLEN), .RF_AW(RF_AW), .LOAD_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex2mem_valid     (ex2mem_valid),
    .ex2mem_reg_wen   (ex2mem_reg_wen),
    .ex2mem_reg_waddr (ex2mem_reg_waddr),
    .ex2mem_alu_out   (ex2mem_alu_out),
    .ex2mem_mem_rd    (ex2mem_mem_rd),
    .ex2mem_ld_type   (ex2mem_ld_type),
    .ex2mem_ill_instr (ex2mem_ill_instr),
    .mem_flush        (mem_flush),
    .lsu_rvalid       (lsu_rvalid),
    .lsu_rdata        (lsu_rdata),
    .mem_stall        (mem_stall),
    .mem2wb_valid     (mem2wb_valid),
    .mem2wb_reg_wen   (mem2wb_reg_wen),
    .mem2wb_ill_instr (mem2wb_ill_instr),
    .mem2wb_ld_fault  (mem2wb_ld_fault),
    .mem2wb_reg_waddr (mem2wb_reg_waddr),
    .mem2wb_reg_wdata (mem2wb_reg_wdata),
    .mem_fwd_wen      (mem_fwd_wen),
    .mem_fwd_addr     (mem_fwd_addr),
    .mem_fwd_data     (mem_fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one instruction slot plus the LSU response for the coming edge.
  task automatic put(input logic v, input logic wen, input logic [RF_AW-1:0] wa,
                     input logic [XLEN-1:0] alu, input logic rd, input logic [2:0] lt,
                     input logic ill, input logic fl, input logic rv,
                     input logic [XLEN-1:0] rdata);
    ex2mem_valid     = v;
    ex2mem_reg_wen   = wen;
    ex2mem_reg_waddr = wa;
    ex2mem_alu_out   = alu;
    ex2mem_mem_rd    = rd;
    ex2mem_ld_type   = lt;
    ex2mem_ill_instr = ill;
    mem_flush        = fl;
    lsu_rvalid       = rv;
    lsu_rdata        = rdata;
  endtask

  task automatic expect_ret(input logic wen, input logic [RF_AW-1:0] wa,
                            input logic [XLEN-1:0] wd, input logic ill, input logic fault);
    ret_t r;
    r.wen = wen; r.waddr = wa; r.wdata = wd; r.ill = ill; r.fault = fault;
    exp_q.push_back(r);
  endtask

  // Check the combinational stall, then advance one full cycle.
  task automatic tick(input logic exp_stall, input string nm);
    #1;
    check(nm, 32'(mem_stall), 32'(exp_stall));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(mem2wb_valid), 32'd0);
    check({tag, "_wen"},   32'(mem2wb_reg_wen), 32'd0);
    check({tag, "_ill"},   32'(mem2wb_ill_instr), 32'd0);
    check({tag, "_fault"}, 32'(mem2wb_ld_fault), 32'd0);
    check({tag, "_waddr"}, 32'(mem2wb_reg_waddr), 32'd0);
    check({tag, "_wdata"}, mem2wb_reg_wdata, 32'd0);
  endtask

  // Monitor: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    if (mem2wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 32'(mem2wb_valid), 32'd0);
      end else begin
        ret_t e;
        e = exp_q.pop_front();
        check("ret_wen",   32'(mem2wb_reg_wen),   32'(e.wen));
        check("ret_waddr", 32'(mem2wb_reg_waddr), 32'(e.waddr));
        check("ret_wdata", mem2wb_reg_wdata,      e.wdata);
        check("ret_ill",   32'(mem2wb_ill_instr), 32'(e.ill));
        check("ret_fault", 32'(mem2wb_ld_fault),  32'(e.fault));
      end
    end
  end

  initial begin
    rst = 1'b1;
    put(1, 1, 5'd1, 32'h0, 1, 3'b010, 0, 0, 0, 32'h0);
    @(negedge clk);
    // Reset: stall must be low even with a load waiting.
    tick(0, "stall_in_reset");
    put(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 0, 32'h0);
    tick(0, "stall_in_reset2");
    check_reset_outputs("rst");
    rst = 1'b0;

    // ALU op and forwarding.
    put(1, 1, 5'd5, 32'h1234, 0, 3'b000, 0, 0, 0, 32'h0);
    #1;
    check("fwd_wen",  32'(mem_fwd_wen), 32'd1);
    check("fwd_addr", 32'(mem_fwd_addr), 32'd5);
    check("fwd_data", mem_fwd_data, 32'h1234);
    expect_ret(1, 5'd5, 32'h1234, 0, 0);
    tick(0, "stall_alu");

    // Illegal instruction propagates without a register write.
    put(1, 0, 5'd7, 32'hDEAD_BEEF, 0, 3'b000, 1, 0, 0, 32'h0);
    expect_ret(0, 5'd7, 32'hDEAD_BEEF, 1, 0);
    tick(0, "stall_ill");

    // Same-cycle loads: LB, LBU, reserved code as LW, LHU.
    put(1, 1, 5'd3, 32'h0000_0103, 1, 3'b000, 0, 0, 1, 32'h80FF_0000);
    #1;
    check("fwd_wen_load", 32'(mem_fwd_wen), 32'd0);
    expect_ret(1, 5'd3, 32'hFFFF_FF80, 0, 0);
    tick(0, "stall_lb");
    put(1, 1, 5'd3, 32'h0000_0103, 1, 3'b100, 0, 0, 1, 32'h80FF_0000);
    expect_ret(1, 5'd3, 32'h0000_0080, 0, 0);
    tick(0, "stall_lbu");
    put(1, 1, 5'd2, 32'h0000_0100, 1, 3'b111, 0, 0, 1, 32'h1357_9BDF);
    expect_ret(1, 5'd2, 32'h1357_9BDF, 0, 0);
    tick(0, "stall_lw_rsvd");
    put(1, 1, 5'd2, 32'h0000_0100, 1, 3'b101, 0, 0, 1, 32'h8001_7FFF);
    expect_ret(1, 5'd2, 32'h0000_7FFF, 0, 0);
    tick(0, "stall_lhu");

    // LH with response three cycles after issue.
    put(1, 1, 5'd9, 32'h0000_0202, 1, 3'b001, 0, 0, 0, 32'h0);
    tick(1, "lh_wait0");
    tick(1, "lh_wait1");
    tick(1, "lh_wait2");
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h8001_7FFF;
    expect_ret(1, 5'd9, 32'hFFFF_8001, 0, 0);
    tick(0, "lh_resp");

    // Bubble: no retire, waddr/wdata hold.
    put(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 0, 32'h0);
    tick(0, "bubble");
    check("hold_valid", 32'(mem2wb_valid), 32'd0);
    check("hold_wen",   32'(mem2wb_reg_wen), 32'd0);
    check("hold_waddr", 32'(mem2wb_reg_waddr), 32'd9);
    check("hold_wdata", mem2wb_reg_wdata, 32'hFFFF_8001);

    // Timeout with LOAD_TIMEOUT=4: four stall cycles, then a faulted retire.
    put(1, 1, 5'd4, 32'h0000_0300, 1, 3'b010, 0, 0, 0, 32'h0);
    tick(1, "to_stall0");
    tick(1, "to_stall1");
    tick(1, "to_stall2");
    tick(1, "to_stall3");
    expect_ret(0, 5'd4, 32'hFFFF_8001, 0, 1);
    tick(0, "to_fault");
    // DRAIN: loads stall, the late response is dropped, then back to IDLE.
    put(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 0, 32'h0);
    tick(0, "drain_idle");
    put(1, 1, 5'd11, 32'h0000_0000, 1, 3'b100, 0, 0, 0, 32'h0);
    tick(1, "drain_load_stall");
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'hDEAD_0000;
    tick(1, "drain_discard");
    lsu_rdata  = 32'h0000_00AA;
    expect_ret(1, 5'd11, 32'h0000_00AA, 0, 0);
    tick(0, "after_drain_load");
    put(1, 1, 5'd6, 32'h0000_0055, 0, 3'b000, 0, 0, 0, 32'h0);
    expect_ret(1, 5'd6, 32'h0000_0055, 0, 0);
    tick(0, "after_drain_alu");

    // Flush during WAIT without response -> DRAIN, then IDLE.
    put(1, 1, 5'd8, 32'h0000_0400, 1, 3'b010, 0, 0, 0, 32'h0);
    tick(1, "fl_wait");
    mem_flush = 1'b1;
    tick(0, "fl_flush");
    put(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 0, 32'h0);
    tick(0, "fl_bubble");
    put(1, 1, 5'd12, 32'h0000_0500, 1, 3'b010, 0, 0, 0, 32'h0);
    tick(1, "fl_drain_stall");
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h1111_1111;
    tick(1, "fl_discard");
    lsu_rdata  = 32'h2222_2222;
    expect_ret(1, 5'd12, 32'h2222_2222, 0, 0);
    tick(0, "fl_reissue");

    // Flush with same-cycle response in WAIT -> straight back to IDLE.
    put(1, 1, 5'd13, 32'h0000_0600, 1, 3'b010, 0, 0, 0, 32'h0);
    tick(1, "flrv_wait");
    mem_flush  = 1'b1;
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h4444_4444;
    tick(0, "flrv_flush");
    put(1, 1, 5'd14, 32'h0000_0700, 1, 3'b010, 0, 0, 1, 32'h3333_3333);
    expect_ret(1, 5'd14, 32'h3333_3333, 0, 0);
    tick(0, "flrv_idle_load");

    // Flush of an ALU op in IDLE: no forward, no retire.
    put(1, 1, 5'd15, 32'h0000_0777, 0, 3'b000, 0, 1, 0, 32'h0);
    #1;
    check("fwd_wen_flush", 32'(mem_fwd_wen), 32'd0);
    tick(0, "fl_alu");

    // Reset during WAIT abandons the load; a stray response is ignored.
    put(1, 1, 5'd10, 32'h0000_0800, 1, 3'b010, 0, 0, 0, 32'h0);
    tick(1, "rw_wait0");
    tick(1, "rw_wait1");
    rst = 1'b1;
    tick(0, "rw_reset");
    check_reset_outputs("rw");
    rst = 1'b0;
    put(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 1, 32'h5555_5555);
    tick(0, "rw_stray");
    check("rw_stray_valid", 32'(mem2wb_valid), 32'd0);
    put(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 0, 32'h0);
    tick(0, "end_idle");
    tick(0, "end_idle2");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data width; only 32 is supported for sub-word loads.
REQ-002 Parameter RF_AW, default 5, SHALL set register address width (4 for RV32E).
REQ-003 Parameter LOAD_TIMEOUT, default 16, range 2..255, SHALL set the maximum number of WAIT cycles before a load fault.
REQ-004 Port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, in, 1: reset, synchronous and active-high.
REQ-006 Port ex2mem_valid, in, 1: an instruction is present in EX/MEM.
REQ-007 Port ex2mem_reg_wen, in, 1: the instruction writes the register file.
REQ-008 Port ex2mem_reg_waddr, in, RF_AW: destination register.
REQ-009 Port ex2mem_alu_out, in, XLEN: ALU result or load address.
REQ-010 Port ex2mem_mem_rd, in, 1: the instruction is a load.
REQ-011 Port ex2mem_ld_type, in, 3: load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-012 Port ex2mem_ill_instr, in, 1: illegal-instruction flag.
REQ-013 Port mem_flush, in, 1: kill the instruction currently in MEM.
REQ-014 Port lsu_rvalid, in, 1: load response valid.
REQ-015 Port lsu_rdata, in, XLEN: word-aligned load response data.
REQ-016 Port mem_stall, out, 1: combinational; EX/MEM SHALL hold its outputs while it is high.
REQ-017 Ports mem2wb_valid, mem2wb_reg_wen, mem2wb_ill_instr, mem2wb_ld_fault, out, 1 each: registered pipeline flags.
REQ-018 Port mem2wb_reg_waddr, out, RF_AW: registered destination register.
REQ-019 Port mem2wb_reg_wdata, out, XLEN: registered write data.
REQ-020 Port mem_fwd_wen, out, 1: combinational forward enable, equal to ex2mem_valid & ex2mem_reg_wen & ~ex2mem_mem_rd & ~mem_flush.
REQ-021 Port mem_fwd_addr, out, RF_AW: forward address, equal to ex2mem_reg_waddr.
REQ-022 Port mem_fwd_data, out, XLEN: forward data, equal to ex2mem_alu_out.

Function
REQ-023 The FSM SHALL have three states: IDLE, WAIT (load outstanding), DRAIN (discard one orphaned response).
REQ-024 A load is "issued" when the FSM is in IDLE and ex2mem_valid & ex2mem_mem_rd is high.
REQ-025 IDLE, non-load valid instruction: next cycle mem2wb_valid=1, reg_wen/waddr/ill copied from inputs, wdata=ex2mem_alu_out; latency 1.
REQ-026 IDLE, load issued with lsu_rvalid high the same cycle: complete in 1 cycle with the extended data; mem_stall=0.
REQ-027 IDLE, load issued with lsu_rvalid low: mem_stall=1, go to WAIT, timeout counter cleared to 0.
REQ-028 WAIT: mem_stall = ~lsu_rvalid; each cycle without rvalid increments the counter.
REQ-029 WAIT with lsu_rvalid high: retire the load next cycle, return to IDLE.
REQ-030 WAIT with counter == LOAD_TIMEOUT-1 and no rvalid: retire with mem2wb_ld_fault=1, reg_wen=0, valid=1; go to DRAIN; mem_stall=0 that cycle.
REQ-031 DRAIN: mem_stall = ex2mem_valid & ex2mem_mem_rd; the first lsu_rvalid is discarded and the FSM returns to IDLE; a new load is not issued until the FSM is in IDLE.
REQ-032 Load extension: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-033 Reserved ld_type codes (011, 110, 111) SHALL be treated as LW.
REQ-034 When no instruction retires in a cycle, mem2wb_valid=0 and mem2wb_reg_wen=0; waddr and wdata hold their previous values.
REQ-035 mem_flush in IDLE: the instruction does not retire (valid=0, reg_wen=0); if it was a load with no same-cycle rvalid, go to DRAIN.
REQ-036 mem_flush in WAIT: no retire; rvalid in the same cycle returns the FSM to IDLE, otherwise go to DRAIN; mem_stall=0 that cycle.
REQ-037 mem_flush has priority over rvalid completion and over timeout.
REQ-038 ill_instr SHALL propagate on retire regardless of reg_wen.

Reset
REQ-039 On rst: state=IDLE, counter=0, and mem2wb_valid, reg_wen, ill_instr, ld_fault, waddr and wdata all = 0.
REQ-040 Reset mid-WAIT or mid-DRAIN SHALL abandon the outstanding load; any later rvalid seen in IDLE SHALL be ignored.
REQ-041 mem_stall SHALL be 0 during reset.

Verification
REQ-042 ALU op: valid=1, wen=1, waddr=5, alu_out=0x1234 -> next cycle valid=1, wen=1, waddr=5, wdata=0x1234, stall=0.
REQ-043 LB, addr=0x...3, rdata=0x80FF_0000, rvalid in the same cycle -> wdata=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-044 LH, addr=0x...2, rvalid after 3 cycles with rdata=0x8001_7FFF -> stall high for 3 cycles, then wdata=0xFFFF_8001.
REQ-045 Load with no rvalid, LOAD_TIMEOUT=4 -> stall high 4 cycles, then ld_fault=1, wen=0; a late rvalid is dropped in DRAIN; the next ALU op retires normally.
REQ-046 Flush during WAIT, then rvalid 2 cycles later -> no retire, state DRAIN then IDLE, no register write.
REQ-047 rst asserted during WAIT -> all outputs 0 next cycle, stall=0; a subsequent stray rvalid in IDLE produces no retire.
